sample_feeder: RTL and testbench
================================

Name: sample_feeder

Overview:
- Reader counterpart to the vote result buffer: fetches feature vectors that the PS has written into the sample BRAM.
- Streams them, one feature per beat, into the tree engines over a valid/ready interface.
- Drives only the fabric-side BRAM read port (BRAM instantiated by parent; PS owns the other port).
- Run controlled by start/count inputs; reports busy/done.

Parameters:
- FEAT_WIDTH, 16, width of one feature value (low bits of each 32-bit BRAM word)
- DEPTH_BIT, 13, BRAM word-address width
- NFEAT_BIT, 8, width of per-sample feature count
- BRAM_LAT, 2, BRAM read latency in cycles (addr/en to dout valid), 1..3

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_buffer_rst  in  1  synchronous abort/flush of current run
- i_start  in  1  one-cycle start pulse
- i_num_samples  in  DEPTH_BIT  samples in run, sampled at start
- i_num_feat  in  NFEAT_BIT  features per sample, sampled at start
- o_bram_en  out  1  read enable to BRAM port A
- o_bram_addr  out  DEPTH_BIT  word address to BRAM port A
- i_bram_dout  in  32  BRAM port A read data
- o_feat_vld  out  1  feature beat valid
- i_feat_rdy  in  1  downstream ready
- o_feat_val  out  FEAT_WIDTH  feature value = i_bram_dout[FEAT_WIDTH-1:0]
- o_feat_last  out  1  beat is last feature of its sample
- o_sample_last  out  1  beat is last feature of last sample
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse, run complete

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, FSM IDLE, counters/FIFO cleared. Reset mid-run discards everything; no done pulse.
- Addressing:
  - Reads linear from word 0; total words N = i_num_samples * i_num_feat, computed at start in DEPTH_BIT+NFEAT_BIT bits.
  - Address wraps modulo 2^DEPTH_BIT; callers keep N <= 2^DEPTH_BIT, and larger N is not checked.
- FSM:
  - IDLE: o_busy=0. On i_start, latch counts → FETCH. If N=0 → DONE directly.
  - FETCH: issue one read per cycle while issued < N and (fifo_count + inflight) < BRAM_LAT+2. When issued == N → DRAIN.
  - DRAIN: wait until inflight=0 and the last beat is accepted (vld&rdy) → DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 → IDLE.
- o_busy=1 in FETCH and DRAIN only; i_start there is ignored.
- Read pipeline:
  - A BRAM_LAT-deep valid shift register tracks in-flight reads.
  - Returning data plus its last/sample_last tags enter a FIFO of depth BRAM_LAT+2.
  - The credit rule guarantees the FIFO never overflows; reads are never dropped or reissued.
- Output handshake:
  - o_feat_vld = FIFO non-empty; data/tags come from the FIFO head.
  - A beat transfers on vld&rdy. vld, once asserted, stays asserted and the data stays stable until accepted.
  - With i_feat_rdy held 1, sustained throughput is 1 beat/cycle; the first beat appears BRAM_LAT+1 cycles after the start cycle.
- Tags:
  - feature counter 0..num_feat-1, sample counter 0..num_samples-1, both advanced at issue time.
  - o_feat_last set when feature counter = num_feat-1.
  - o_sample_last set when additionally sample counter = num_samples-1.
- Simultaneous FIFO push and pop: count unchanged, both honoured.
- i_buffer_rst:
  - Any state → IDLE next cycle; FIFO and in-flight tracker flushed; o_feat_vld=0 next cycle; no done pulse.
  - Data returning afterwards is discarded.
  - Has priority over i_start in the same cycle.
- Upper bits i_bram_dout[31:FEAT_WIDTH] are ignored.

Test Plan:
- Basic:
  - Stimulus: BRAM words 0..5 = 0x10..0x15; start with samples=2, feat=3; rdy=1.
  - Response: 6 beats 0x10..0x15 on consecutive cycles; feat_last on beats 3 and 6; sample_last on beat 6 only; first vld at start+3 (BRAM_LAT=2); done 1 cycle after last accept.
- Backpressure:
  - Stimulus: same run; rdy toggles 1,0,0,1 repeating.
  - Response: identical 6-beat sequence, no loss/duplication; data stable while vld&!rdy; issued-but-unaccepted never exceeds 4.
- Zero count:
  - Stimulus: samples=0, feat=5.
  - Response: no bram_en; done pulse within 2 cycles; busy never asserted beyond DONE.
- Abort:
  - Stimulus: samples=4, feat=4; assert i_buffer_rst after 5 beats accepted.
  - Response: vld=0 next cycle; busy=0; no done; a new start then replays from word 0.
- Start ignored/reset:
  - Stimulus: pulse i_start during FETCH.
  - Response: run unaffected, exactly one done.
  - Stimulus: rst_n=0 mid-DRAIN.
  - Response: all outputs 0 at next edge.
- Wrap/max:
  - Stimulus: samples=1, feat=255, rdy=1.
  - Response: addresses 0..254 in order; feat_last and sample_last both on beat 255.

Source files
------------

// File: rtl/sample_feeder.sv
// sample_feeder
//   Reads feature vectors that the PS has placed in the sample BRAM and
//   streams them to the tree engines, one feature per valid/ready beat.
//   Only the fabric-side BRAM read port is driven here.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   i_buffer_rst     synchronous abort: flush the run and return to idle
//   i_start          one-cycle start pulse (ignored while busy)
//   i_num_samples    samples in the run, captured at start
//   i_num_feat       features per sample, captured at start
//   o_bram_en        BRAM port A read enable
//   o_bram_addr      BRAM port A word address
//   i_bram_dout      BRAM port A read data (low FEAT_WIDTH bits used)
//   o_feat_vld       feature beat valid
//   i_feat_rdy       downstream ready
//   o_feat_val       feature value
//   o_feat_last      beat is the last feature of its sample
//   o_sample_last    beat is the last feature of the last sample
//   o_busy           run in progress
//   o_done           one-cycle pulse when the run completes
module sample_feeder #(
  parameter int unsigned FEAT_WIDTH = 16,
  parameter int unsigned DEPTH_BIT  = 13,
  parameter int unsigned NFEAT_BIT  = 8,
  parameter int unsigned BRAM_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_buffer_rst,
  input  logic                  i_start,
  input  logic [DEPTH_BIT-1:0]  i_num_samples,
  input  logic [NFEAT_BIT-1:0]  i_num_feat,
  output logic                  o_bram_en,
  output logic [DEPTH_BIT-1:0]  o_bram_addr,
  input  logic [31:0]           i_bram_dout,
  output logic                  o_feat_vld,
  input  logic                  i_feat_rdy,
  output logic [FEAT_WIDTH-1:0] o_feat_val,
  output logic                  o_feat_last,
  output logic                  o_sample_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned TW     = DEPTH_BIT + NFEAT_BIT;
  localparam int unsigned FDEPTH = BRAM_LAT + 2;
  localparam int unsigned PW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int unsigned CW     = $clog2(FDEPTH + 1);
  localparam int unsigned OW     = CW + 1;
  localparam int unsigned EW     = FEAT_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_BIT-1:0]   nsamp_q;
  logic [NFEAT_BIT-1:0]   nfeat_q;
  logic [TW-1:0]          total_q;
  logic [TW-1:0]          issued_q;
  logic [DEPTH_BIT-1:0]   addr_q;
  logic [NFEAT_BIT-1:0]   fcnt_q;
  logic [DEPTH_BIT-1:0]   scnt_q;

  // In-flight read tracker with the tags that travel alongside each read.
  logic [BRAM_LAT-1:0]    vsr_q;
  logic [BRAM_LAT-1:0]    flast_pipe_q;
  logic [BRAM_LAT-1:0]    slast_pipe_q;

  logic [EW-1:0]          fifo_mem_q [FDEPTH];
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [CW-1:0]          fcount_q;

  logic [TW-1:0]          total_start;
  logic                   start_take;
  logic [CW-1:0]          inflight;
  logic [OW-1:0]          occ;
  logic                   issue;
  logic                   issue_flast;
  logic                   issue_slast;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          head;
  logic                   unused_dout;

  assign unused_dout = ^i_bram_dout[31:FEAT_WIDTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign total_start = TW'(i_num_samples) * TW'(i_num_feat);
  assign start_take  = (state_q == S_IDLE) && i_start && !i_buffer_rst;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < BRAM_LAT; i++) begin
      inflight = inflight + CW'(vsr_q[i]);
    end
  end

  // Credit: everything issued but not yet popped must fit in the FIFO.
  assign occ   = OW'(fcount_q) + OW'(inflight);
  assign issue = (state_q == S_FETCH) && !i_buffer_rst &&
                 (issued_q < total_q) && (occ < OW'(FDEPTH));

  assign issue_flast = (fcnt_q == nfeat_q - 1'b1);
  assign issue_slast = issue_flast && (scnt_q == nsamp_q - 1'b1);

  assign push = vsr_q[BRAM_LAT-1];
  assign head = fifo_mem_q[rptr_q];

  assign o_feat_vld    = (fcount_q != '0);
  assign pop           = o_feat_vld && i_feat_rdy;
  assign o_feat_val    = o_feat_vld ? head[FEAT_WIDTH-1:0] : '0;
  assign o_feat_last   = o_feat_vld && head[FEAT_WIDTH];
  assign o_sample_last = o_feat_vld && head[FEAT_WIDTH+1];
  assign o_bram_en     = issue;
  assign o_bram_addr   = issue ? addr_q : '0;
  assign o_busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign o_done        = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (total_start == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue && (issued_q + TW'(1) == total_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Final beat is the only FIFO entry and nothing is still in flight.
        if ((inflight == '0) && (fcount_q == CW'(1)) && pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_buffer_rst) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      nsamp_q      <= '0;
      nfeat_q      <= '0;
      total_q      <= '0;
      issued_q     <= '0;
      addr_q       <= '0;
      fcnt_q       <= '0;
      scnt_q       <= '0;
      vsr_q        <= '0;
      flast_pipe_q <= '0;
      slast_pipe_q <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fcount_q     <= '0;
    end else begin
      state_q <= state_d;

      if (start_take) begin
        nsamp_q  <= i_num_samples;
        nfeat_q  <= i_num_feat;
        total_q  <= total_start;
        issued_q <= '0;
        addr_q   <= '0;
        fcnt_q   <= '0;
        scnt_q   <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
        addr_q   <= addr_q + 1'b1;
        if (issue_flast) begin
          fcnt_q <= '0;
          scnt_q <= scnt_q + 1'b1;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end

      if (i_buffer_rst) begin
        vsr_q <= '0;
      end else begin
        for (int unsigned i = BRAM_LAT - 1; i > 0; i--) begin
          vsr_q[i] <= vsr_q[i-1];
        end
        vsr_q[0] <= issue;
      end
      for (int unsigned i = BRAM_LAT - 1; i > 0; i--) begin
        flast_pipe_q[i] <= flast_pipe_q[i-1];
        slast_pipe_q[i] <= slast_pipe_q[i-1];
      end
      flast_pipe_q[0] <= issue_flast;
      slast_pipe_q[0] <= issue_slast;

      if (i_buffer_rst) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        fcount_q <= '0;
      end else begin
        if (push) wptr_q <= ptr_inc(wptr_q);
        if (pop)  rptr_q <= ptr_inc(rptr_q);
        if (push && !pop)      fcount_q <= fcount_q + 1'b1;
        else if (!push && pop) fcount_q <= fcount_q - 1'b1;
      end
    end
  end

  // Storage only; validity is carried by the pointers and count above.
  always_ff @(posedge clk) begin
    if (push && rst_n && !i_buffer_rst) begin
      fifo_mem_q[wptr_q] <= {slast_pipe_q[BRAM_LAT-1], flast_pipe_q[BRAM_LAT-1],
                             i_bram_dout[FEAT_WIDTH-1:0]};
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;
  localparam int FW  = 16;
  localparam int DB  = 13;
  localparam int NB  = 8;
  localparam int LAT = 2;
  localparam int MEMW = 1 << DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_buffer_rst;
  logic          i_start;
  logic [DB-1:0] i_num_samples;
  logic [NB-1:0] i_num_feat;
  logic          o_bram_en;
  logic [DB-1:0] o_bram_addr;
  logic [31:0]   i_bram_dout;
  logic          o_feat_vld;
  logic          i_feat_rdy;
  logic [FW-1:0] o_feat_val;
  logic          o_feat_last;
  logic          o_sample_last;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  sample_feeder #(.FEAT_WIDTH(FW), .DEPTH_BIT(DB), .NFEAT_BIT(NB), .BRAM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_buffer_rst(i_buffer_rst), .i_start(i_start),
    .i_num_samples(i_num_samples), .i_num_feat(i_num_feat),
    .o_bram_en(o_bram_en), .o_bram_addr(o_bram_addr), .i_bram_dout(i_bram_dout),
    .o_feat_vld(o_feat_vld), .i_feat_rdy(i_feat_rdy), .o_feat_val(o_feat_val),
    .o_feat_last(o_feat_last), .o_sample_last(o_sample_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  // BRAM port A behavioural model, LAT cycles from en/addr to dout.
  logic [31:0] mem [MEMW];
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= o_bram_en ? mem[o_bram_addr] : 32'($urandom);
  end
  assign i_bram_dout = pipe[LAT-1];

  // Ready pattern generator: 0 always, 1 = 1,0,0,1 repeating, 2 random, 3 never.
  int rdy_mode = 0;
  int rdy_phase = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: i_feat_rdy = 1'b1;
      1: begin i_feat_rdy = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3); rdy_phase++; end
      2: i_feat_rdy = 1'($urandom % 2);
      default: i_feat_rdy = 1'b0;
    endcase
  end

  // Observation: everything recorded at the falling edge, i.e. describing
  // what the next rising edge will do.
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          en_cnt = 0;
  int          busy_cnt = 0;
  int          stab_err = 0;
  int          out_cnt = 0;
  int          out_hist[$];
  int          acc_cyc[$];
  logic [17:0] beats[$];
  logic [DB-1:0] addr_log[$];
  logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_ok = 1'b0;
  logic [17:0] prev_beat = '0;

  always @(negedge clk) begin
    cyc++;
    if (o_bram_en === 1'b1) begin
      en_cnt++;
      addr_log.push_back(o_bram_addr);
    end
    if (o_feat_vld === 1'b1 && i_feat_rdy === 1'b1) begin
      beats.push_back({o_sample_last, o_feat_last, o_feat_val});
      acc_cyc.push_back(cyc);
    end
    if (prev_vld && !prev_rdy && prev_ok) begin
      if (o_feat_vld !== 1'b1 || {o_sample_last, o_feat_last, o_feat_val} !== prev_beat) stab_err++;
    end
    if (rst_n !== 1'b1 || i_buffer_rst === 1'b1) out_cnt = 0;
    else out_cnt = out_cnt + int'(o_bram_en === 1'b1) - int'(o_feat_vld === 1'b1 && i_feat_rdy === 1'b1);
    out_hist.push_back(out_cnt);
    if (o_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (o_busy === 1'b1) busy_cnt++;
    prev_vld  = (o_feat_vld === 1'b1);
    prev_rdy  = (i_feat_rdy === 1'b1);
    prev_ok   = (rst_n === 1'b1) && (i_buffer_rst !== 1'b1);
    prev_beat = {o_sample_last, o_feat_last, o_feat_val};
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];

  // Reference: linear walk over samples and features, word address modulo depth.
  task automatic build_exp(input int ns, input int nf);
    logic [31:0] w;
    exp_q.delete();
    for (int s = 0; s < ns; s++)
      for (int f = 0; f < nf; f++) begin
        w = mem[(s * nf + f) % MEMW];
        exp_q.push_back({(f == nf - 1) && (s == ns - 1), f == nf - 1, w[15:0]});
      end
  endtask

  task automatic start_run(input int ns, input int nf);
    @(posedge clk); #1;
    i_num_samples = DB'(ns);
    i_num_feat    = NB'(nf);
    i_start       = 1'b1;
    @(posedge clk); #1;
    i_start       = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_buffer_rst = 1'b0; i_start = 1'b0;
    i_num_samples = '0; i_num_feat = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_bram_en, o_bram_addr, o_feat_vld, o_feat_val, o_feat_last, o_sample_last, o_busy, o_done} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got vld=%b busy=%b done=%b en=%b want all 0", o_feat_vld, o_busy, o_done, o_bram_en);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_feat_vld, o_busy, o_done, o_bram_en} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_after_reset: got vld=%b busy=%b done=%b en=%b want 0", o_feat_vld, o_busy, o_done, o_bram_en);
    end
  endtask

  task automatic test_basic();
    int b0, a0, d0, n;
    bit ok;
    logic [2:0] vseq;
    for (int i = 0; i < 6; i++) mem[i] = {16'($urandom), 16'(16'h10 + i)};
    rdy_mode = 0;
    build_exp(2, 3);
    b0 = beats.size(); a0 = acc_cyc.size(); d0 = done_cnt;
    start_run(2, 3);
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", o_busy); end
    vseq = '0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; vseq[k] = o_feat_vld; end
    n_cmp++;
    if (vseq !== 3'b100) begin n_bad++; $display("FAIL basic_first_vld: got %b want 100", vseq); end
    wait_done(d0, 100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_done_timeout: got no done want done"); end
    n = beats.size() - b0;
    n_cmp++;
    if (n != 6) begin n_bad++; $display("FAIL basic_count: got %0d want 6", n); end
    for (int i = 0; i < n && i < 6; i++) begin
      n_cmp++;
      if (beats[b0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_beat%0d: got %h want %h", i, beats[b0 + i], exp_q[i]); end
    end
    if (n == 6) begin
      n_cmp++;
      if (acc_cyc[a0 + 5] - acc_cyc[a0] != 5) begin n_bad++; $display("FAIL basic_throughput: got span %0d want 5", acc_cyc[a0 + 5] - acc_cyc[a0]); end
      n_cmp++;
      if (done_cyc != acc_cyc[a0 + 5] + 1) begin n_bad++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, acc_cyc[a0 + 5] + 1); end
    end
  endtask

  task automatic test_backpressure();
    int b0, d0, h0, s0, n, mx;
    bit ok;
    rdy_mode = 1;
    build_exp(2, 3);
    b0 = beats.size(); d0 = done_cnt; h0 = out_hist.size(); s0 = stab_err;
    start_run(2, 3);
    wait_done(d0, 200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_done_timeout: got no done want done"); end
    n = beats.size() - b0;
    n_cmp++;
    if (n != 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", n); end
    for (int i = 0; i < n && i < 6; i++) begin
      n_cmp++;
      if (beats[b0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", i, beats[b0 + i], exp_q[i]); end
    end
    mx = 0;
    for (int i = h0; i < out_hist.size(); i++) if (out_hist[i] > mx) mx = out_hist[i];
    n_cmp++;
    if (mx > LAT + 2) begin n_bad++; $display("FAIL bp_outstanding: got %0d want <= %0d", mx, LAT + 2); end
    n_cmp++;
    if (stab_err != s0) begin n_bad++; $display("FAIL bp_stable: got %0d violations want 0", stab_err - s0); end
    rdy_mode = 0;
  endtask

  task automatic test_zero();
    int d0, e0, bz;
    bit ok;
    d0 = done_cnt; e0 = en_cnt; bz = busy_cnt;
    start_run(0, 5);
    wait_done(d0, 2, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL zero_done: got no done within 2 want done"); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (en_cnt != e0) begin n_bad++; $display("FAIL zero_no_read: got %0d reads want 0", en_cnt - e0); end
    n_cmp++;
    if (busy_cnt != bz) begin n_bad++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt - bz); end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int b0, d0, n, k;
    bit ok;
    rdy_mode = 0;
    b0 = beats.size(); d0 = done_cnt;
    start_run(4, 4);
    k = 0;
    while (beats.size() - b0 < 5 && k < 100) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (beats.size() - b0 < 5) begin n_bad++; $display("FAIL abort_progress: got %0d beats want 5", beats.size() - b0); end
    i_buffer_rst = 1'b1;
    @(posedge clk); #1;
    i_buffer_rst = 1'b0;
    n_cmp++;
    if ({o_feat_vld, o_busy} !== 2'b00) begin n_bad++; $display("FAIL abort_flush: got vld=%b busy=%b want 0 0", o_feat_vld, o_busy); end
    // Restart immediately so stale reads are still in the BRAM pipe.
    build_exp(1, 3);
    b0 = beats.size();
    start_run(1, 3);
    wait_done(d0, 100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL abort_restart_timeout: got no done want done"); end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL abort_no_done: got %0d dones want 1", done_cnt - d0); end
    n = beats.size() - b0;
    n_cmp++;
    if (n != 3) begin n_bad++; $display("FAIL abort_replay_count: got %0d want 3", n); end
    for (int i = 0; i < n && i < 3; i++) begin
      n_cmp++;
      if (beats[b0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_replay%0d: got %h want %h", i, beats[b0 + i], exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int b0, d0, e0, n;
    bit ok;
    rdy_mode = 2;
    build_exp(3, 4);
    b0 = beats.size(); d0 = done_cnt; e0 = en_cnt;
    start_run(3, 4);
    repeat (2) @(posedge clk);
    #1;
    i_num_samples = DB'(1); i_num_feat = NB'(1); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(d0, 300, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ign_done_timeout: got no done want done"); end
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++;
    if (en_cnt - e0 != 12) begin n_bad++; $display("FAIL ign_reads: got %0d want 12", en_cnt - e0); end
    n = beats.size() - b0;
    n_cmp++;
    if (n != 12) begin n_bad++; $display("FAIL ign_count: got %0d want 12", n); end
    for (int i = 0; i < n && i < 12; i++) begin
      n_cmp++;
      if (beats[b0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL ign_beat%0d: got %h want %h", i, beats[b0 + i], exp_q[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_drain();
    int d0;
    rdy_mode = 3;
    d0 = done_cnt;
    start_run(1, 3);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_busy, o_feat_vld} !== 2'b11) begin n_bad++; $display("FAIL drain_stall: got busy=%b vld=%b want 1 1", o_busy, o_feat_vld); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({o_bram_en, o_bram_addr, o_feat_vld, o_feat_val, o_feat_last, o_sample_last, o_busy, o_done} !== '0) begin
      n_bad++; $display("FAIL drain_reset: got vld=%b busy=%b done=%b val=%h want all 0", o_feat_vld, o_busy, o_done, o_feat_val);
    end
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL drain_reset_done: got %0d dones want 0", done_cnt - d0); end
  endtask

  task automatic test_wrap_max();
    int b0, a0, l0, d0, n;
    bit ok;
    rdy_mode = 0;
    build_exp(1, 255);
    b0 = beats.size(); a0 = acc_cyc.size(); l0 = addr_log.size(); d0 = done_cnt;
    start_run(1, 255);
    wait_done(d0, 600, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL max_done_timeout: got no done want done"); end
    n_cmp++;
    if (addr_log.size() - l0 != 255) begin n_bad++; $display("FAIL max_reads: got %0d want 255", addr_log.size() - l0); end
    for (int i = 0; i < addr_log.size() - l0 && i < 255; i++) begin
      n_cmp++;
      if (addr_log[l0 + i] !== DB'(i)) begin n_bad++; $display("FAIL max_addr%0d: got %0d want %0d", i, addr_log[l0 + i], i); end
    end
    n = beats.size() - b0;
    n_cmp++;
    if (n != 255) begin n_bad++; $display("FAIL max_count: got %0d want 255", n); end
    for (int i = 0; i < n && i < 255; i++) begin
      n_cmp++;
      if (beats[b0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL max_beat%0d: got %h want %h", i, beats[b0 + i], exp_q[i]); end
    end
    if (n == 255) begin
      n_cmp++;
      if (acc_cyc[a0 + 254] - acc_cyc[a0] != 254) begin n_bad++; $display("FAIL max_throughput: got span %0d want 254", acc_cyc[a0 + 254] - acc_cyc[a0]); end
    end
  endtask

  task automatic test_random();
    int b0, d0, n, ns, nf;
    bit ok;
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      ns = $urandom_range(1, 5);
      nf = $urandom_range(1, 12);
      build_exp(ns, nf);
      b0 = beats.size(); d0 = done_cnt;
      start_run(ns, nf);
      wait_done(d0, 600, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rnd%0d_timeout: got no done want done", r); end
      n = beats.size() - b0;
      n_cmp++;
      if (n != ns * nf) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", r, n, ns * nf); end
      for (int i = 0; i < n && i < ns * nf; i++) begin
        n_cmp++;
        if (beats[b0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_beat%0d: got %h want %h", r, i, beats[b0 + i], exp_q[i]); end
      end
      repeat (2) @(posedge clk);
    end
    rdy_mode = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = 32'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_abort();
    test_start_ignored();
    test_reset_mid_drain();
    test_wrap_max();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
